br_comp_seq: RTL

- Multi-cycle, slice-serial branch comparator for the branch unit.
- Resolves all RV32 conditional branches: BEQ, BNE, BLT, BGE, BLTU and BGEU.
- Compares operands SLICE_WIDTH bits per cycle, starting at the most significant slice, and stops at the first slice that differs.
- Uses start/busy/done handshaking. Can be flushed by the pipeline control.
- Trades latency for a narrow comparator on area- and timing-constrained builds.

---
 rtl/br_comp_seq_if.sv | 26 ++
 rtl/br_comp_seq.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/br_comp_seq_if.sv
// rtl/br_comp_seq_if.sv - request/result bundle between the branch unit and br_comp_seq
interface br_comp_seq_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic                  flush;
    logic [DATA_WIDTH-1:0] br_in_1;
    logic [DATA_WIDTH-1:0] br_in_2;
    logic [2:0]            funct3;
    logic                  busy;
    logic                  done;
    logic                  BrEq;
    logic                  BrLt;
    logic                  BrTaken;
    logic                  illegal;

    modport master (
        output start, flush, br_in_1, br_in_2, funct3,
        input  busy, done, BrEq, BrLt, BrTaken, illegal
    );

    modport slave (
        input  start, flush, br_in_1, br_in_2, funct3,
        output busy, done, BrEq, BrLt, BrTaken, illegal
    );
endinterface

// File: rtl/br_comp_seq.sv
// rtl/br_comp_seq.sv - slice-serial RV32 branch comparator, MSB slice first, early exit
module br_comp_seq #(
    parameter int DATA_WIDTH  = 32,
    parameter int SLICE_WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    br_comp_seq_if.slave  bus
);
    localparam int NUM_SLICES = DATA_WIDTH / SLICE_WIDTH;
    localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Latched request; operands shift left one slice per step so the
    // slice under test always sits in the top SLICE_WIDTH bits.
    logic [DATA_WIDTH-1:0]  r_op1;
    logic [DATA_WIDTH-1:0]  r_op2;
    logic [2:0]             r_funct3;
    logic [IDX_W-1:0]       r_idx;

    logic                   r_eq;
    logic                   r_lt;
    logic                   r_taken;
    logic                   r_illegal;

    logic                   w_accept;
    logic                   w_finish;
    logic                   w_step;
    logic                   w_flip;
    logic [SLICE_WIDTH-1:0] w_flip_mask;
    logic [SLICE_WIDTH-1:0] w_s1;
    logic [SLICE_WIDTH-1:0] w_s2;
    logic                   w_slice_eq;
    logic                   w_slice_lt;
    logic                   w_res_taken;
    logic                   w_res_illegal;

    // Signed compare of the top slice is an unsigned compare with the sign bit inverted.
    assign w_flip      = ~r_funct3[1] && (r_idx == LAST_IDX);
    assign w_flip_mask = SLICE_WIDTH'(w_flip) << (SLICE_WIDTH - 1);
    assign w_s1        = r_op1[DATA_WIDTH-1 -: SLICE_WIDTH] ^ w_flip_mask;
    assign w_s2        = r_op2[DATA_WIDTH-1 -: SLICE_WIDTH] ^ w_flip_mask;
    assign w_slice_eq  = (w_s1 == w_s2);
    assign w_slice_lt  = (w_s1 < w_s2);

    // Branch decision from the latched funct3 and the result about to be registered.
    always_comb begin
        w_res_taken   = 1'b0;
        w_res_illegal = 1'b0;
        case (r_funct3)
            3'b000:         w_res_taken = w_slice_eq;
            3'b001:         w_res_taken = ~w_slice_eq;
            3'b100, 3'b110: w_res_taken = ~w_slice_eq & w_slice_lt;
            3'b101, 3'b111: w_res_taken = ~(~w_slice_eq & w_slice_lt);
            default:        w_res_illegal = 1'b1;
        endcase
    end

    // Next-state logic; flush outranks start and completion.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_finish     = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.flush) begin
                    w_state_next = ST_IDLE;
                end else if (bus.start) begin
                    w_state_next = ST_CMP;
                    w_accept     = 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_CMP: begin
                if (bus.flush) begin
                    w_state_next = ST_IDLE;
                end else if (!w_slice_eq || (r_idx == '0)) begin
                    w_state_next = ST_DONE;
                    w_finish     = 1'b1;
                end else begin
                    w_step       = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand latch/shift and result registers; results persist until the next completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op1     <= '0;
            r_op2     <= '0;
            r_funct3  <= '0;
            r_idx     <= '0;
            r_eq      <= 1'b0;
            r_lt      <= 1'b0;
            r_taken   <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op1    <= bus.br_in_1;
                r_op2    <= bus.br_in_2;
                r_funct3 <= bus.funct3;
                r_idx    <= LAST_IDX;
            end else if (w_step) begin
                r_op1    <= r_op1 << SLICE_WIDTH;
                r_op2    <= r_op2 << SLICE_WIDTH;
                r_idx    <= r_idx - 1'b1;
            end
            if (w_finish) begin
                r_eq      <= w_slice_eq;
                r_lt      <= ~w_slice_eq & w_slice_lt;
                r_taken   <= w_res_taken;
                r_illegal <= w_res_illegal;
            end
        end
    end

    assign bus.busy    = (r_state == ST_CMP);
    assign bus.done    = (r_state == ST_DONE);
    assign bus.BrEq    = r_eq;
    assign bus.BrLt    = r_lt;
    assign bus.BrTaken = r_taken;
    assign bus.illegal = r_illegal;
endmodule
